// File: rtl/pzcorebus_request_1_to_m_multicast_switch.sv
// Request-path 1-to-M switch: a per-command destination mask routes each command to any subset
// of masters, tracks acceptance per destination and replicates write beats to every destination.
module pzcorebus_request_1_to_m_multicast_switch #(
    parameter int MASTERS          = 4,
    parameter int ID_WIDTH         = 8,
    parameter int ADDRESS_WIDTH    = 32,
    parameter int INFO_WIDTH       = 4,
    parameter int DATA_WIDTH       = 64,
    parameter int CMD_WIDTH        = 3,
    parameter int WAIT_FOR_COMMAND = 1
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic [MASTERS-1:0]       i_select,
    input  logic                     i_mcmd_valid,
    output logic                     o_scmd_accept,
    input  logic [CMD_WIDTH-1:0]     i_mcmd,
    input  logic                     i_mcmd_data,
    input  logic [ID_WIDTH-1:0]      i_mid,
    input  logic [ADDRESS_WIDTH-1:0] i_maddr,
    input  logic [INFO_WIDTH-1:0]    i_minfo,
    input  logic                     i_mdata_valid,
    output logic                     o_sdata_accept,
    input  logic [DATA_WIDTH-1:0]    i_mdata,
    input  logic                     i_mdata_last,
    output logic [MASTERS-1:0]       o_mcmd_valid,
    input  logic [MASTERS-1:0]       i_scmd_accept,
    output logic [CMD_WIDTH-1:0]     o_mcmd,
    output logic [ID_WIDTH-1:0]      o_mid,
    output logic [ADDRESS_WIDTH-1:0] o_maddr,
    output logic [INFO_WIDTH-1:0]    o_minfo,
    output logic                     o_mcmd_data,
    output logic [MASTERS-1:0]       o_mdata_valid,
    input  logic [MASTERS-1:0]       i_sdata_accept,
    output logic [DATA_WIDTH-1:0]    o_mdata,
    output logic                     o_mdata_last,
    output logic                     o_null_select
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] DATA = 1'b1;

    logic [0:0]         state_q, state_d;
    logic [MASTERS-1:0] cmd_done_q, cmd_done_d;
    logic [MASTERS-1:0] beat_done_q, beat_done_d;
    logic [MASTERS-1:0] data_mask_q, data_mask_d;
    logic               null_select_q, null_select_d;

    logic               cmd_enable;
    logic               cmd_fire;
    logic               data_fire;
    logic [MASTERS-1:0] cmd_ack_ok;
    logic [MASTERS-1:0] data_ack_ok;
    logic [MASTERS-1:0] fwd_mask;

    assign o_mcmd        = i_mcmd;
    assign o_mid         = i_mid;
    assign o_maddr       = i_maddr;
    assign o_minfo       = i_minfo;
    assign o_mcmd_data   = i_mcmd_data;
    assign o_mdata       = i_mdata;
    assign o_mdata_last  = i_mdata_last;
    assign o_null_select = null_select_q;

    always_comb begin
        cmd_enable    = (state_q == IDLE);
        cmd_ack_ok    = ~i_select | cmd_done_q | i_scmd_accept;
        o_scmd_accept = cmd_enable & (&cmd_ack_ok);
        o_mcmd_valid  = {MASTERS{i_mcmd_valid & cmd_enable}} & i_select & ~cmd_done_q;
        cmd_fire      = i_mcmd_valid & o_scmd_accept;

        // Without WAIT_FOR_COMMAND, a beat may reach a master early, but the slave only sees
        // the beat accepted once the command itself completes in the same cycle.
        fwd_mask       = '0;
        data_ack_ok    = '1;
        o_sdata_accept = 1'b0;
        if (state_q == DATA) begin
            fwd_mask       = data_mask_q;
            data_ack_ok    = ~data_mask_q | beat_done_q | i_sdata_accept;
            o_sdata_accept = &data_ack_ok;
        end else if ((WAIT_FOR_COMMAND == 0) && i_mcmd_valid && i_mcmd_data) begin
            fwd_mask       = i_select & (cmd_done_q | i_scmd_accept);
            data_ack_ok    = ~i_select | beat_done_q | i_sdata_accept;
            o_sdata_accept = cmd_fire & (&data_ack_ok);
        end

        o_mdata_valid = {MASTERS{i_mdata_valid}} & fwd_mask & ~beat_done_q;
        data_fire     = i_mdata_valid & o_sdata_accept;
    end

    always_comb begin
        cmd_done_d    = cmd_fire  ? '0 : (cmd_done_q  | (o_mcmd_valid  & i_scmd_accept));
        beat_done_d   = data_fire ? '0 : (beat_done_q | (o_mdata_valid & i_sdata_accept));
        null_select_d = cmd_fire & (i_select == '0);
        state_d       = state_q;
        data_mask_d   = data_mask_q;
        case (state_q)
            IDLE: begin
                if (cmd_fire && i_mcmd_data && !(data_fire && i_mdata_last)) begin
                    state_d     = DATA;
                    data_mask_d = i_select;
                end
            end
            DATA: begin
                if (data_fire && i_mdata_last) begin
                    state_d     = IDLE;
                    data_mask_d = '0;
                end
            end
            default: begin
                state_d     = IDLE;
                data_mask_d = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q       <= IDLE;
            cmd_done_q    <= '0;
            beat_done_q   <= '0;
            data_mask_q   <= '0;
            null_select_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cmd_done_q    <= cmd_done_d;
            beat_done_q   <= beat_done_d;
            data_mask_q   <= data_mask_d;
            null_select_q <= null_select_d;
        end
    end

endmodule

// File: tb/tb_pzcorebus_request_1_to_m_multicast_switch.sv
// Directed bench for the multicast request switch: one task per scenario, each with its own
// hand-computed expectations, default parameters (4 masters, WAIT_FOR_COMMAND=1).
module tb_pzcorebus_request_1_to_m_multicast_switch;

    logic        i_clk;
    logic        i_rst;
    logic [3:0]  i_select;
    logic        i_mcmd_valid;
    logic        o_scmd_accept;
    logic [2:0]  i_mcmd;
    logic        i_mcmd_data;
    logic [7:0]  i_mid;
    logic [31:0] i_maddr;
    logic [3:0]  i_minfo;
    logic        i_mdata_valid;
    logic        o_sdata_accept;
    logic [63:0] i_mdata;
    logic        i_mdata_last;
    logic [3:0]  o_mcmd_valid;
    logic [3:0]  i_scmd_accept;
    logic [2:0]  o_mcmd;
    logic [7:0]  o_mid;
    logic [31:0] o_maddr;
    logic [3:0]  o_minfo;
    logic        o_mcmd_data;
    logic [3:0]  o_mdata_valid;
    logic [3:0]  i_sdata_accept;
    logic [63:0] o_mdata;
    logic        o_mdata_last;
    logic        o_null_select;

    int assert_count = 0;
    int fail_count   = 0;

    pzcorebus_request_1_to_m_multicast_switch dut (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_select       (i_select),
        .i_mcmd_valid   (i_mcmd_valid),
        .o_scmd_accept  (o_scmd_accept),
        .i_mcmd         (i_mcmd),
        .i_mcmd_data    (i_mcmd_data),
        .i_mid          (i_mid),
        .i_maddr        (i_maddr),
        .i_minfo        (i_minfo),
        .i_mdata_valid  (i_mdata_valid),
        .o_sdata_accept (o_sdata_accept),
        .i_mdata        (i_mdata),
        .i_mdata_last   (i_mdata_last),
        .o_mcmd_valid   (o_mcmd_valid),
        .i_scmd_accept  (i_scmd_accept),
        .o_mcmd         (o_mcmd),
        .o_mid          (o_mid),
        .o_maddr        (o_maddr),
        .o_minfo        (o_minfo),
        .o_mcmd_data    (o_mcmd_data),
        .o_mdata_valid  (o_mdata_valid),
        .i_sdata_accept (i_sdata_accept),
        .o_mdata        (o_mdata),
        .o_mdata_last   (o_mdata_last),
        .o_null_select  (o_null_select)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic drive_idle();
        i_select       = 4'b0000;
        i_mcmd_valid   = 1'b0;
        i_mcmd         = 3'd0;
        i_mcmd_data    = 1'b0;
        i_mid          = 8'h00;
        i_maddr        = 32'h0;
        i_minfo        = 4'h0;
        i_mdata_valid  = 1'b0;
        i_mdata        = 64'h0;
        i_mdata_last   = 1'b0;
        i_scmd_accept  = 4'b0000;
        i_sdata_accept = 4'b0000;
    endtask

    task automatic test_reset();
        i_rst = 1'b1;
        drive_idle();
        i_mcmd_valid  = 1'b1;
        i_select      = 4'b1111;
        i_mdata_valid = 1'b1;
        tick();
        tick();
        assert_count++;
        if (o_mcmd_valid !== 4'b1111) begin
            fail_count++;
            $display("[TB] FAIL reset_cmd_comb: got %b expected %b", o_mcmd_valid, 4'b1111);
        end
        assert_count++;
        if (o_mdata_valid !== 4'b0000) begin
            fail_count++;
            $display("[TB] FAIL reset_mdata_valid: got %b expected %b", o_mdata_valid, 4'b0000);
        end
        assert_count++;
        if (o_null_select !== 1'b0) begin
            fail_count++;
            $display("[TB] FAIL reset_null_select: got %b expected 0", o_null_select);
        end
        drive_idle();
        i_rst = 1'b0;
        #1;
        assert_count++;
        if (o_mcmd_valid !== 4'b0000) begin
            fail_count++;
            $display("[TB] FAIL reset_mcmd_valid: got %b expected %b", o_mcmd_valid, 4'b0000);
        end
        tick();
    endtask

    task automatic test_unicast();
        i_select      = 4'b0100;
        i_mcmd_valid  = 1'b1;
        i_mcmd        = 3'd1;
        i_mid         = 8'h5A;
        i_maddr       = 32'h1000_0040;
        i_minfo       = 4'h9;
        i_scmd_accept = 4'b0010;
        #1;
        assert_count++;
        if (o_scmd_accept !== 1'b0) begin
            fail_count++;
            $display("[TB] FAIL unicast_wrong_acceptor: got %b expected 0", o_scmd_accept);
        end
        i_scmd_accept = 4'b0100;
        #1;
        assert_count++;
        if (o_mcmd_valid !== 4'b0100) begin
            fail_count++;
            $display("[TB] FAIL unicast_valid: got %b expected %b", o_mcmd_valid, 4'b0100);
        end
        assert_count++;
        if (o_scmd_accept !== 1'b1) begin
            fail_count++;
            $display("[TB] FAIL unicast_accept: got %b expected 1", o_scmd_accept);
        end
        assert_count++;
        if (o_maddr !== 32'h1000_0040 || o_mid !== 8'h5A || o_minfo !== 4'h9 || o_mcmd !== 3'd1) begin
            fail_count++;
            $display("[TB] FAIL unicast_payload: got %h/%h/%h/%h expected 10000040/5a/9/1",
                     o_maddr, o_mid, o_minfo, o_mcmd);
        end
        tick();
        drive_idle();
        tick();
    endtask

    task automatic test_multicast_staggered();
        logic [3:0] acc_pat   [0:5];
        logic [3:0] exp_valid [0:5];
        int         seen      [0:3];
        acc_pat[0] = 4'b0001; exp_valid[0] = 4'b1011;
        acc_pat[1] = 4'b0000; exp_valid[1] = 4'b1010;
        acc_pat[2] = 4'b0010; exp_valid[2] = 4'b1010;
        acc_pat[3] = 4'b0000; exp_valid[3] = 4'b1000;
        acc_pat[4] = 4'b0000; exp_valid[4] = 4'b1000;
        acc_pat[5] = 4'b1000; exp_valid[5] = 4'b1000;
        for (int m = 0; m < 4; m++) seen[m] = 0;
        i_select     = 4'b1011;
        i_mcmd_valid = 1'b1;
        for (int c = 0; c < 6; c++) begin
            i_scmd_accept = acc_pat[c];
            #1;
            assert_count++;
            if (o_mcmd_valid !== exp_valid[c]) begin
                fail_count++;
                $display("[TB] FAIL stagger_valid c%0d: got %b expected %b", c, o_mcmd_valid, exp_valid[c]);
            end
            assert_count++;
            if (o_scmd_accept !== (c == 5)) begin
                fail_count++;
                $display("[TB] FAIL stagger_accept c%0d: got %b expected %b", c, o_scmd_accept, (c == 5));
            end
            for (int m = 0; m < 4; m++)
                if (o_mcmd_valid[m] && i_scmd_accept[m]) seen[m]++;
            tick();
        end
        for (int m = 0; m < 4; m++) begin
            assert_count++;
            if (seen[m] !== ((m == 2) ? 0 : 1)) begin
                fail_count++;
                $display("[TB] FAIL stagger_seen m%0d: got %0d expected %0d", m, seen[m], (m == 2) ? 0 : 1);
            end
        end
        // A fresh command must see clean per-master tracking.
        i_select      = 4'b0001;
        i_scmd_accept = 4'b0000;
        #1;
        assert_count++;
        if (o_mcmd_valid !== 4'b0001) begin
            fail_count++;
            $display("[TB] FAIL stagger_cleared: got %b expected %b", o_mcmd_valid, 4'b0001);
        end
        drive_idle();
        tick();
    endtask

    task automatic test_multicast_write();
        logic [3:0] sacc_pat [0:6];
        logic [3:0] exp_vld  [0:6];
        logic       exp_acc  [0:6];
        int         beat;
        int         m0_beats;
        int         acc_cnt;
        sacc_pat[0] = 4'b0011; exp_vld[0] = 4'b0011; exp_acc[0] = 1'b1;
        sacc_pat[1] = 4'b0001; exp_vld[1] = 4'b0011; exp_acc[1] = 1'b0;
        sacc_pat[2] = 4'b0001; exp_vld[2] = 4'b0010; exp_acc[2] = 1'b0;
        sacc_pat[3] = 4'b0001; exp_vld[3] = 4'b0010; exp_acc[3] = 1'b0;
        sacc_pat[4] = 4'b0011; exp_vld[4] = 4'b0010; exp_acc[4] = 1'b1;
        sacc_pat[5] = 4'b0011; exp_vld[5] = 4'b0011; exp_acc[5] = 1'b1;
        sacc_pat[6] = 4'b0011; exp_vld[6] = 4'b0011; exp_acc[6] = 1'b1;
        beat     = 0;
        m0_beats = 0;
        acc_cnt  = 0;
        i_select      = 4'b0011;
        i_mcmd_valid  = 1'b1;
        i_mcmd_data   = 1'b1;
        i_scmd_accept = 4'b0011;
        #1;
        assert_count++;
        if (o_scmd_accept !== 1'b1) begin
            fail_count++;
            $display("[TB] FAIL write_cmd_accept: got %b expected 1", o_scmd_accept);
        end
        tick();
        drive_idle();
        i_mdata_valid = 1'b1;
        for (int c = 0; c < 7; c++) begin
            i_mdata        = 64'hA000_0000_0000_0000 + 64'(beat);
            i_mdata_last   = (beat == 3);
            i_sdata_accept = sacc_pat[c];
            #1;
            assert_count++;
            if (o_mdata_valid !== exp_vld[c] || o_sdata_accept !== exp_acc[c]) begin
                fail_count++;
                $display("[TB] FAIL write_beat c%0d: got valid %b accept %b expected %b %b",
                         c, o_mdata_valid, o_sdata_accept, exp_vld[c], exp_acc[c]);
            end
            if (c == 0) begin
                assert_count++;
                if (o_scmd_accept !== 1'b0 || o_mdata !== 64'hA000_0000_0000_0000) begin
                    fail_count++;
                    $display("[TB] FAIL write_data_state: got scmd_accept %b mdata %h expected 0 a000000000000000",
                             o_scmd_accept, o_mdata);
                end
            end
            if (o_mdata_valid[0] && i_sdata_accept[0]) m0_beats++;
            if (o_sdata_accept) begin
                acc_cnt++;
                beat++;
            end
            tick();
        end
        assert_count++;
        if (m0_beats !== 4 || acc_cnt !== 4) begin
            fail_count++;
            $display("[TB] FAIL write_counts: got m0 %0d accepts %0d expected 4 4", m0_beats, acc_cnt);
        end
        drive_idle();
        i_select      = 4'b0001;
        i_mcmd_valid  = 1'b1;
        i_scmd_accept = 4'b0001;
        #1;
        assert_count++;
        if (o_scmd_accept !== 1'b1) begin
            fail_count++;
            $display("[TB] FAIL write_back_idle: got %b expected 1", o_scmd_accept);
        end
        tick();
        drive_idle();
        tick();
    endtask

    task automatic test_null_select();
        i_select     = 4'b0000;
        i_mcmd_valid = 1'b1;
        i_mcmd_data  = 1'b1;
        #1;
        assert_count++;
        if (o_scmd_accept !== 1'b1 || o_mcmd_valid !== 4'b0000) begin
            fail_count++;
            $display("[TB] FAIL null_cmd: got accept %b valid %b expected 1 0000", o_scmd_accept, o_mcmd_valid);
        end
        tick();
        drive_idle();
        for (int b = 0; b < 2; b++) begin
            i_mdata_valid = 1'b1;
            i_mdata_last  = (b == 1);
            #1;
            assert_count++;
            if (o_null_select !== (b == 0)) begin
                fail_count++;
                $display("[TB] FAIL null_pulse b%0d: got %b expected %b", b, o_null_select, (b == 0));
            end
            assert_count++;
            if (o_sdata_accept !== 1'b1 || o_mdata_valid !== 4'b0000) begin
                fail_count++;
                $display("[TB] FAIL null_drop b%0d: got accept %b valid %b expected 1 0000",
                         b, o_sdata_accept, o_mdata_valid);
            end
            tick();
        end
        drive_idle();
        #1;
        assert_count++;
        if (o_null_select !== 1'b0) begin
            fail_count++;
            $display("[TB] FAIL null_pulse_end: got %b expected 0", o_null_select);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        int accepted;
        accepted      = 0;
        i_mcmd_valid  = 1'b1;
        i_scmd_accept = 4'b1111;
        for (int c = 0; c < 8; c++) begin
            i_select = (c % 2 == 0) ? 4'b0001 : 4'b1000;
            i_maddr  = 32'h2000 + 32'(c);
            #1;
            assert_count++;
            if (o_mcmd_valid !== i_select || o_scmd_accept !== 1'b1) begin
                fail_count++;
                $display("[TB] FAIL b2b c%0d: got valid %b accept %b expected %b 1",
                         c, o_mcmd_valid, o_scmd_accept, i_select);
            end
            if (o_scmd_accept) accepted++;
            tick();
        end
        assert_count++;
        if (accepted !== 8) begin
            fail_count++;
            $display("[TB] FAIL b2b_throughput: got %0d expected 8", accepted);
        end
        drive_idle();
        tick();
    endtask

    task automatic test_reset_mid_burst();
        i_select      = 4'b1111;
        i_mcmd_valid  = 1'b1;
        i_mcmd_data   = 1'b1;
        i_scmd_accept = 4'b1111;
        tick();
        drive_idle();
        i_mdata_valid  = 1'b1;
        i_sdata_accept = 4'b1111;
        tick();
        i_sdata_accept = 4'b0101;
        #1;
        assert_count++;
        if (o_mdata_valid !== 4'b1111 || o_sdata_accept !== 1'b0) begin
            fail_count++;
            $display("[TB] FAIL midrst_beat2: got valid %b accept %b expected 1111 0",
                     o_mdata_valid, o_sdata_accept);
        end
        tick();
        i_sdata_accept = 4'b0000;
        i_rst          = 1'b1;
        #1;
        assert_count++;
        if (o_mdata_valid !== 4'b0000 || o_mcmd_valid !== 4'b0000) begin
            fail_count++;
            $display("[TB] FAIL midrst_async: got data %b cmd %b expected 0000 0000",
                     o_mdata_valid, o_mcmd_valid);
        end
        tick();
        i_rst = 1'b0;
        drive_idle();
        tick();
        i_select      = 4'b0010;
        i_mcmd_valid  = 1'b1;
        i_scmd_accept = 4'b0010;
        #1;
        assert_count++;
        if (o_mcmd_valid !== 4'b0010 || o_scmd_accept !== 1'b1) begin
            fail_count++;
            $display("[TB] FAIL midrst_next_cmd: got valid %b accept %b expected 0010 1",
                     o_mcmd_valid, o_scmd_accept);
        end
        tick();
        drive_idle();
        tick();
    endtask

    initial begin
        test_reset();
        test_unicast();
        test_multicast_staggered();
        test_multicast_write();
        test_null_select();
        test_back_to_back();
        test_reset_mid_burst();
        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
